// File: rtl/y86_bus_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single shared memory bus.
// Fixed-latency accesses with WAIT_STATES extra cycles; round-robin on contention.
module y86_bus_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] bus_A,
    output logic [31:0] bus_out,
    input  logic [31:0] bus_in,
    output logic        bus_WE,
    output logic        bus_RE,
    output logic [1:0]  grant,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic [1:0]  owner;
    logic        last_dma;
    logic [3:0]  cnt;
    logic        pick_cpu;
    logic        pick_dma;

    // CPU wins unless DMA also asks and CPU won the previous grant.
    always_comb begin
        pick_cpu = cpu_req && (!dma_req || last_dma);
        pick_dma = dma_req && !pick_cpu;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req || dma_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            owner     <= 2'b00;
            last_dma  <= 1'b1;
            cnt       <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_cpu) begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        lat_we    <= cpu_we;
                        owner     <= 2'b01;
                        last_dma  <= 1'b0;
                        cnt       <= WS;
                    end else if (pick_dma) begin
                        lat_addr  <= dma_addr;
                        lat_wdata <= dma_wdata;
                        lat_we    <= dma_we;
                        owner     <= 2'b10;
                        last_dma  <= 1'b1;
                        cnt       <= WS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Read data is sampled on the last strobe cycle.
                        if (!lat_we) begin
                            if (owner[0]) cpu_rdata <= bus_in;
                            else          dma_rdata <= bus_in;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    owner <= 2'b00;
                default: owner <= 2'b00;
            endcase
        end
    end

    always_comb begin
        bus_A   = '0;
        bus_out = '0;
        bus_WE  = 1'b0;
        bus_RE  = 1'b0;
        grant   = 2'b00;
        cpu_ack = 1'b0;
        dma_ack = 1'b0;
        case (state)
            ACCESS: begin
                bus_A   = lat_addr;
                bus_out = lat_wdata;
                bus_WE  = lat_we;
                bus_RE  = !lat_we;
                grant   = owner;
            end
            DONE: begin
                grant   = owner;
                cpu_ack = owner[0];
                dma_ack = owner[1];
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Scoreboard bench for y86_bus_arbiter: drivers push expected transactions,
// a negedge monitor pops and checks them on every ack.
module tb_y86_bus_arbiter;

    localparam int W_MAIN = 1;
    localparam int XW     = 98;  // {port, we, addr, wdata, rdata}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] cpu_rdata, dma_rdata, bus_A, bus_out, bus_in;
    logic        cpu_ack, dma_ack, bus_WE, bus_RE;
    logic [1:0]  grant, dbg_state;

    always #5 clk = ~clk;

    assign bus_in = (bus_A == 32'h100) ? 32'hDEADBEEF : ~bus_A;

    y86_bus_arbiter #(.WAIT_STATES(W_MAIN)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_A(bus_A), .bus_out(bus_out), .bus_in(bus_in),
        .bus_WE(bus_WE), .bus_RE(bus_RE), .grant(grant), .dbg_state(dbg_state)
    );

    // Auxiliary instances for other WAIT_STATES values (CPU port only).
    logic        a0_req = 1'b0, a3_req = 1'b0, a_zero = 1'b0;
    logic [31:0] a_addr = '0, a_zero32 = '0;
    logic [31:0] a0_crd, a0_drd, a0_A, a0_out, a0_in;
    logic [31:0] a3_crd, a3_drd, a3_A, a3_out, a3_in;
    logic        a0_cack, a0_dack, a0_WE, a0_RE, a3_cack, a3_dack, a3_WE, a3_RE;
    logic [1:0]  a0_gnt, a0_dbg, a3_gnt, a3_dbg;

    assign a0_in = (a0_A == 32'h100) ? 32'hDEADBEEF : ~a0_A;
    assign a3_in = (a3_A == 32'h100) ? 32'hDEADBEEF : ~a3_A;

    y86_bus_arbiter #(.WAIT_STATES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .cpu_req(a0_req), .cpu_we(a_zero), .cpu_addr(a_addr), .cpu_wdata(a_zero32),
        .cpu_rdata(a0_crd), .cpu_ack(a0_cack),
        .dma_req(a_zero), .dma_we(a_zero), .dma_addr(a_zero32), .dma_wdata(a_zero32),
        .dma_rdata(a0_drd), .dma_ack(a0_dack),
        .bus_A(a0_A), .bus_out(a0_out), .bus_in(a0_in),
        .bus_WE(a0_WE), .bus_RE(a0_RE), .grant(a0_gnt), .dbg_state(a0_dbg)
    );

    y86_bus_arbiter #(.WAIT_STATES(3)) dut_w3 (
        .clk(clk), .rst(rst),
        .cpu_req(a3_req), .cpu_we(a_zero), .cpu_addr(a_addr), .cpu_wdata(a_zero32),
        .cpu_rdata(a3_crd), .cpu_ack(a3_cack),
        .dma_req(a_zero), .dma_we(a_zero), .dma_addr(a_zero32), .dma_wdata(a_zero32),
        .dma_rdata(a3_drd), .dma_ack(a3_dack),
        .bus_A(a3_A), .bus_out(a3_out), .bus_in(a3_in),
        .bus_WE(a3_WE), .bus_RE(a3_RE), .grant(a3_gnt), .dbg_state(a3_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [XW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_cpu_rd = '0, exp_dma_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // rd_exp is the hand-computed read value; ignored for writes (rdata must hold).
    task automatic push(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd_exp);
        logic [31:0] rd;
        if (!we) begin
            if (port) exp_dma_rd = rd_exp;
            else      exp_cpu_rd = rd_exp;
        end
        rd = port ? exp_dma_rd : exp_cpu_rd;
        exp_q.push_back({port, we, addr, wdata, rd});
    endtask

    // ---------------- monitor ----------------
    int          width = 0, lat = 0;
    bit          in_txn = 0;
    logic [31:0] cap_addr, cap_out;
    logic        cap_we;

    always @(negedge clk) begin
        if (!rst) begin
            width  = 0;
            in_txn = 0;
        end else begin
            logic [XW-1:0] e;
            if (bus_WE && bus_RE) chk("strobes_both_high", 32'(1), 32'(0));
            if (cpu_ack && dma_ack) chk("acks_both_high", 32'(1), 32'(0));
            if (bus_WE || bus_RE) begin
                width++;
                cap_addr = bus_A;
                cap_out  = bus_out;
                cap_we   = bus_WE;
            end
            if (in_txn) lat++;
            else if (grant != 2'b00) begin
                in_txn = 1;
                lat    = 0;
            end
            if (cpu_ack || dma_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {30'd0, dma_ack, cpu_ack}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", {31'd0, dma_ack}, {31'd0, e[97]});
                    chk("grant", {30'd0, grant}, e[97] ? 32'd2 : 32'd1);
                    chk("bus_we", {31'd0, cap_we}, {31'd0, e[96]});
                    chk("bus_addr", cap_addr, e[95:64]);
                    if (e[96]) chk("bus_wdata", cap_out, e[63:32]);
                    chk("strobe_width", 32'(width), 32'(W_MAIN + 1));
                    chk("ack_latency", 32'(lat), 32'(W_MAIN + 1));
                    chk("rdata", e[97] ? dma_rdata : cpu_rdata, e[31:0]);
                end
                width  = 0;
                in_txn = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit drop_early);
        bit got = 0;
        @(negedge clk);
        if (port) begin
            dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (drop_early) begin
                cpu_req = 0; dma_req = 0;
            end
            if ((port && dma_ack) || (!port && cpu_ack)) got = 1;
        end
        cpu_req = 0; dma_req = 0;
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic both_access(input int n_acks, input logic [31:0] caddr, input logic [31:0] daddr);
        int acks = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = caddr;
        dma_req = 1; dma_we = 0; dma_addr = daddr;
        for (int i = 0; i < 100 && acks < n_acks; i++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) acks++;
        end
        cpu_req = 0; dma_req = 0;
        chk("contention_acks", 32'(acks), 32'(n_acks));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        exp_cpu_rd = '0;
        exp_dma_rd = '0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit seen, dack;
        int w0, w3, ack0, ack3;
        repeat (3) @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_bus_A", bus_A, 32'd0);
        chk("rst_strobes", {30'd0, bus_WE, bus_RE}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_state", {30'd0, dbg_state}, 32'd0);
        rst = 1;
        @(negedge clk);
        chk("idle_outputs", bus_A | bus_out | {28'd0, grant, bus_WE, bus_RE}, 32'd0);

        // Single CPU read, DMA write, DMA read, CPU write
        push(0, 0, 32'h100, 32'h0, 32'hDEADBEEF);
        do_access(0, 0, 32'h100, 32'h0, 0);
        push(1, 1, 32'h40, 32'h12345678, 32'h0);
        do_access(1, 1, 32'h40, 32'h12345678, 0);
        push(1, 0, 32'h44, 32'h0, 32'hFFFFFFBB);
        do_access(1, 0, 32'h44, 32'h0, 0);
        push(0, 1, 32'h80, 32'hCAFEF00D, 32'h0);
        do_access(0, 1, 32'h80, 32'hCAFEF00D, 0);

        // Contention from reset: CPU, DMA, CPU, DMA
        reset_pulse();
        push(0, 0, 32'h200, 32'h0, 32'hFFFFFDFF);
        push(1, 0, 32'h300, 32'h0, 32'hFFFFFCFF);
        push(0, 0, 32'h200, 32'h0, 32'hFFFFFDFF);
        push(1, 0, 32'h300, 32'h0, 32'hFFFFFCFF);
        both_access(4, 32'h200, 32'h300);

        // CPU drops request mid-access
        push(0, 0, 32'h100, 32'h0, 32'hDEADBEEF);
        do_access(0, 0, 32'h100, 32'h0, 1);
        repeat (2) @(negedge clk);
        chk("grant_after_drop", {30'd0, grant}, 32'd0);

        // Reset in the middle of a DMA write: no ack, outputs cleared
        @(negedge clk);
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h55AA55AA;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_WE) seen = 1;
        end
        chk("abort_write_started", 32'(seen), 32'd1);
        #2 rst = 0;
        #1;
        chk("abort_bus", bus_A | bus_out, 32'd0);
        chk("abort_ctrl", {26'd0, grant, bus_WE, bus_RE, cpu_ack, dma_ack}, 32'd0);
        chk("abort_rdata", cpu_rdata | dma_rdata, 32'd0);
        dma_req = 0;
        exp_cpu_rd = '0;
        exp_dma_rd = '0;
        dack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dma_ack) dack = 1;
        end
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dma_ack) dack = 1;
        end
        chk("abort_no_dma_ack", 32'(dack), 32'd0);
        push(0, 0, 32'h100, 32'h0, 32'hDEADBEEF);
        push(1, 0, 32'h44, 32'h0, 32'hFFFFFFBB);
        both_access(2, 32'h100, 32'h44);

        // WAIT_STATES = 0 and 3: strobe width and ack latency
        @(negedge clk);
        a_addr = 32'h100; a0_req = 1; a3_req = 1;
        w0 = 0; w3 = 0; ack0 = 0; ack3 = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (a0_RE) w0++;
            if (a3_RE) w3++;
            if (a0_cack) begin
                if (ack0 == 0) ack0 = n;
                a0_req = 0;
            end
            if (a3_cack) begin
                if (ack3 == 0) ack3 = n;
                a3_req = 0;
            end
        end
        a0_req = 0; a3_req = 0;
        chk("w0_strobe_width", 32'(w0), 32'd1);
        chk("w3_strobe_width", 32'(w3), 32'd4);
        chk("w0_ack_cycle", 32'(ack0), 32'd2);
        chk("w3_ack_cycle", 32'(ack3), 32'd5);
        chk("w0_rdata", a0_crd, 32'hDEADBEEF);
        chk("w3_rdata", a3_crd, 32'hDEADBEEF);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
